vx_tl_mem_bridge: RTL and testbench

Parametrised bridge between the Vortex core memory port (VX mem req/rsp) and a TileLink-UL master port (A/D channels). It supports up to 2^SOURCE_WIDTH outstanding transactions via a source-ID allocator and tag table, buffers responses in a FIFO, and can optionally return write acknowledgements to the core. It also stretches the software interrupt (msip) rising edge into a fixed-length irq pulse. It sits between VX_core and the tile's TileLink fabric, replacing the single-outstanding, combinational core wrapper glue.

---
 rtl/vx_tl_mem_bridge_if.sv | 67 ++++++
 rtl/vx_tl_mem_bridge.sv | 206 ++++++++++++++++++++
 tb/tb_vx_tl_mem_bridge.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vx_tl_mem_bridge_if.sv
// Bus bundle between the Vortex memory port and a TileLink-UL A/D channel pair.
// The bridge uses the master modport; the core/fabric side uses the slave modport.
interface vx_tl_mem_bridge_if #(
    parameter int unsigned DATA_WIDTH   = 128,
    parameter int unsigned ADDR_WIDTH   = 28,
    parameter int unsigned TAG_WIDTH    = 15,
    parameter int unsigned SOURCE_WIDTH = 2
);
    localparam int unsigned BYTES         = DATA_WIDTH / 8;
    localparam int unsigned TL_ADDR_WIDTH = ADDR_WIDTH + $clog2(BYTES);

    logic                     vx_req_valid;
    logic                     vx_req_rw;
    logic [BYTES-1:0]         vx_req_byteen;
    logic [ADDR_WIDTH-1:0]    vx_req_addr;
    logic [DATA_WIDTH-1:0]    vx_req_data;
    logic [TAG_WIDTH-1:0]     vx_req_tag;
    logic                     vx_req_ready;

    logic                     vx_rsp_valid;
    logic [DATA_WIDTH-1:0]    vx_rsp_data;
    logic [TAG_WIDTH-1:0]     vx_rsp_tag;
    logic                     vx_rsp_ready;

    logic                     tl_a_valid;
    logic                     tl_a_ready;
    logic [2:0]               tl_a_opcode;
    logic [2:0]               tl_a_param;
    logic [3:0]               tl_a_size;
    logic [SOURCE_WIDTH-1:0]  tl_a_source;
    logic [TL_ADDR_WIDTH-1:0] tl_a_address;
    logic [BYTES-1:0]         tl_a_mask;
    logic [DATA_WIDTH-1:0]    tl_a_data;
    logic                     tl_a_corrupt;

    logic                     tl_d_valid;
    logic                     tl_d_ready;
    logic [2:0]               tl_d_opcode;
    logic [SOURCE_WIDTH-1:0]  tl_d_source;
    logic [DATA_WIDTH-1:0]    tl_d_data;
    logic                     tl_d_denied;
    logic                     tl_d_corrupt;

    modport master (
        input  vx_req_valid, vx_req_rw, vx_req_byteen, vx_req_addr, vx_req_data, vx_req_tag,
        output vx_req_ready,
        output vx_rsp_valid, vx_rsp_data, vx_rsp_tag,
        input  vx_rsp_ready,
        output tl_a_valid, tl_a_opcode, tl_a_param, tl_a_size, tl_a_source, tl_a_address,
        output tl_a_mask, tl_a_data, tl_a_corrupt,
        input  tl_a_ready,
        input  tl_d_valid, tl_d_opcode, tl_d_source, tl_d_data, tl_d_denied, tl_d_corrupt,
        output tl_d_ready
    );

    modport slave (
        output vx_req_valid, vx_req_rw, vx_req_byteen, vx_req_addr, vx_req_data, vx_req_tag,
        input  vx_req_ready,
        input  vx_rsp_valid, vx_rsp_data, vx_rsp_tag,
        output vx_rsp_ready,
        input  tl_a_valid, tl_a_opcode, tl_a_param, tl_a_size, tl_a_source, tl_a_address,
        input  tl_a_mask, tl_a_data, tl_a_corrupt,
        output tl_a_ready,
        output tl_d_valid, tl_d_opcode, tl_d_source, tl_d_data, tl_d_denied, tl_d_corrupt,
        input  tl_d_ready
    );
endinterface

// File: rtl/vx_tl_mem_bridge.sv
// Vortex mem port to TileLink-UL bridge: multi-outstanding via source-ID allocation, buffered
// responses, sticky error reporting and an msip-edge interrupt stretcher.
module vx_tl_mem_bridge #(
    parameter int unsigned DATA_WIDTH   = 128,
    parameter int unsigned ADDR_WIDTH   = 28,
    parameter int unsigned TAG_WIDTH    = 15,
    parameter int unsigned SOURCE_WIDTH = 2,
    parameter int unsigned RSP_DEPTH    = 4,
    parameter bit          WRITE_RSP    = 1'b0,
    parameter int unsigned IRQ_PULSE    = 6
) (
    input  logic               clock,
    input  logic               reset,
    vx_tl_mem_bridge_if.master bus,
    input  logic               msip,
    output logic               irq_out,
    output logic               busy,
    output logic               error
);
    localparam int unsigned NUM_IDS       = 1 << SOURCE_WIDTH;
    localparam int unsigned BYTES         = DATA_WIDTH / 8;
    localparam int unsigned LGB           = $clog2(BYTES);
    localparam int unsigned TL_ADDR_WIDTH = ADDR_WIDTH + LGB;
    localparam int unsigned PTR_WIDTH     = $clog2(RSP_DEPTH);

    localparam logic [2:0] OpGet        = 3'd4;
    localparam logic [2:0] OpPutFull    = 3'd0;
    localparam logic [2:0] OpPutPartial = 3'd1;
    localparam logic [2:0] OpAccessAck  = 3'd0;

    // Source-ID allocator and tag table
    logic [NUM_IDS-1:0]      r_free;
    logic [NUM_IDS-1:0]      w_free_d;
    logic [TAG_WIDTH-1:0]    r_tag [NUM_IDS];
    logic [SOURCE_WIDTH-1:0] w_grant;
    logic                    w_any_free;

    // A-channel output register
    logic                     r_a_valid;
    logic [2:0]               r_a_opcode;
    logic [SOURCE_WIDTH-1:0]  r_a_source;
    logic [TL_ADDR_WIDTH-1:0] r_a_address;
    logic [BYTES-1:0]         r_a_mask;
    logic [DATA_WIDTH-1:0]    r_a_data;
    logic                     w_a_can_load;
    logic                     w_req_ready;
    logic                     w_req_fire;
    logic [2:0]               w_req_opcode;

    // D channel and response FIFO
    logic                  w_d_is_ack;
    logic                  w_d_absorb;
    logic                  w_d_ready;
    logic                  w_d_fire;
    logic                  w_d_err;
    logic                  w_push;
    logic                  w_pop;
    logic [DATA_WIDTH-1:0] w_push_data;
    logic [DATA_WIDTH-1:0] r_fifo_data [RSP_DEPTH];
    logic [TAG_WIDTH-1:0]  r_fifo_tag  [RSP_DEPTH];
    logic [PTR_WIDTH:0]    r_wptr;
    logic [PTR_WIDTH:0]    r_rptr;
    logic                  w_fifo_empty;
    logic                  w_fifo_full;

    logic       r_error;
    logic       r_msip_q;
    logic [3:0] r_irq_cnt;

    // Lowest-index free ID wins: scan high to low so the last hit is the lowest.
    always_comb begin
        w_grant    = '0;
        w_any_free = 1'b0;
        for (int i = NUM_IDS - 1; i >= 0; i--) begin
            if (r_free[i]) begin
                w_grant    = SOURCE_WIDTH'(i);
                w_any_free = 1'b1;
            end
        end
    end

    assign w_a_can_load = !r_a_valid || bus.tl_a_ready;
    assign w_req_ready  = !reset && w_any_free && w_a_can_load;
    assign w_req_fire   = bus.vx_req_valid && w_req_ready;

    always_comb begin
        w_req_opcode = OpGet;
        if (bus.vx_req_rw) begin
            w_req_opcode = (&bus.vx_req_byteen) ? OpPutFull : OpPutPartial;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_a_valid   <= 1'b0;
            r_a_opcode  <= '0;
            r_a_source  <= '0;
            r_a_address <= '0;
            r_a_mask    <= '0;
            r_a_data    <= '0;
        end else if (w_a_can_load) begin
            r_a_valid <= w_req_fire;
            if (w_req_fire) begin
                r_a_opcode  <= w_req_opcode;
                r_a_source  <= w_grant;
                r_a_address <= {bus.vx_req_addr, {LGB{1'b0}}};
                r_a_mask    <= bus.vx_req_rw ? bus.vx_req_byteen : {BYTES{1'b1}};
                r_a_data    <= bus.vx_req_data;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_req_fire) begin
            r_tag[w_grant] <= bus.vx_req_tag;
        end
    end

    // A write ack that is not forwarded never needs FIFO space, so it is never stalled.
    assign w_d_is_ack  = (bus.tl_d_opcode == OpAccessAck);
    assign w_d_absorb  = w_d_is_ack && !WRITE_RSP;
    assign w_d_ready   = !reset && (w_d_absorb || !w_fifo_full);
    assign w_d_fire    = bus.tl_d_valid && w_d_ready;
    assign w_push      = w_d_fire && !w_d_absorb;
    assign w_push_data = w_d_is_ack ? '0 : bus.tl_d_data;
    assign w_d_err     = bus.tl_d_denied || bus.tl_d_corrupt || r_free[bus.tl_d_source] ||
                         (bus.tl_d_opcode > 3'd1);

    // A grant always targets a free ID, so apply the release first and the claim last.
    always_comb begin
        w_free_d = r_free;
        if (w_d_fire) begin
            w_free_d[bus.tl_d_source] = 1'b1;
        end
        if (w_req_fire) begin
            w_free_d[w_grant] = 1'b0;
        end
    end

    assign w_fifo_empty = (r_wptr == r_rptr);
    assign w_fifo_full  = (r_wptr[PTR_WIDTH] != r_rptr[PTR_WIDTH]) &&
                          (r_wptr[PTR_WIDTH-1:0] == r_rptr[PTR_WIDTH-1:0]);
    assign w_pop        = !w_fifo_empty && bus.vx_rsp_ready;

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fifo_data[r_wptr[PTR_WIDTH-1:0]] <= w_push_data;
            r_fifo_tag[r_wptr[PTR_WIDTH-1:0]]  <= r_tag[bus.tl_d_source];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_free  <= '1;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_error <= 1'b0;
        end else begin
            r_free <= w_free_d;
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_d_fire && w_d_err) begin
                r_error <= 1'b1;
            end
        end
    end

    // Interrupt stretcher: each msip rising edge (re)loads the pulse counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_msip_q  <= 1'b0;
            r_irq_cnt <= '0;
        end else begin
            r_msip_q <= msip;
            if (msip && !r_msip_q) begin
                r_irq_cnt <= 4'(IRQ_PULSE);
            end else if (r_irq_cnt != 4'd0) begin
                r_irq_cnt <= r_irq_cnt - 4'd1;
            end
        end
    end

    assign bus.vx_req_ready = w_req_ready;
    assign bus.vx_rsp_valid = !w_fifo_empty;
    assign bus.vx_rsp_data  = w_fifo_empty ? '0 : r_fifo_data[r_rptr[PTR_WIDTH-1:0]];
    assign bus.vx_rsp_tag   = w_fifo_empty ? '0 : r_fifo_tag[r_rptr[PTR_WIDTH-1:0]];

    assign bus.tl_a_valid   = r_a_valid;
    assign bus.tl_a_opcode  = r_a_opcode;
    assign bus.tl_a_param   = 3'd0;
    assign bus.tl_a_size    = 4'(LGB);
    assign bus.tl_a_source  = r_a_source;
    assign bus.tl_a_address = r_a_address;
    assign bus.tl_a_mask    = r_a_mask;
    assign bus.tl_a_data    = r_a_data;
    assign bus.tl_a_corrupt = 1'b0;
    assign bus.tl_d_ready   = w_d_ready;

    assign irq_out = (r_irq_cnt != 4'd0);
    assign busy    = (r_free != {NUM_IDS{1'b1}}) || r_a_valid || !w_fifo_empty;
    assign error   = r_error;
endmodule

// File: tb/tb_vx_tl_mem_bridge.sv
// Scoreboard bench for vx_tl_mem_bridge: directed scenarios plus randomized out-of-order
// traffic checked against a queue-based reference model.
module tb_vx_tl_mem_bridge;
    localparam int unsigned DATA_WIDTH    = 128;
    localparam int unsigned ADDR_WIDTH    = 28;
    localparam int unsigned TAG_WIDTH     = 15;
    localparam int unsigned SOURCE_WIDTH  = 2;
    localparam int unsigned RSP_DEPTH     = 4;
    localparam bit          WRITE_RSP     = 1'b0;
    localparam int unsigned IRQ_PULSE     = 6;
    localparam int unsigned NUM_IDS       = 4;
    localparam int unsigned BYTES         = 16;
    localparam int unsigned TL_ADDR_WIDTH = 32;

    typedef struct {
        logic [2:0]               opcode;
        logic [TL_ADDR_WIDTH-1:0] addr;
        logic [BYTES-1:0]         mask;
        logic [DATA_WIDTH-1:0]    data;
        int                       source;
    } a_exp_t;
    typedef struct {
        logic [DATA_WIDTH-1:0] data;
        logic [TAG_WIDTH-1:0]  tag;
    } rsp_t;
    typedef struct {
        int source;
        bit read;
    } infl_t;
    typedef struct {
        logic                    valid;
        logic [2:0]              opcode;
        logic [SOURCE_WIDTH-1:0] source;
        logic [DATA_WIDTH-1:0]   data;
        logic                    denied;
        logic                    corrupt;
    } d_drv_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic msip  = 1'b0;
    logic irq_out, busy, error;

    vx_tl_mem_bridge_if #(
        .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .TAG_WIDTH(TAG_WIDTH),
        .SOURCE_WIDTH(SOURCE_WIDTH)
    ) bus ();

    vx_tl_mem_bridge #(
        .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .TAG_WIDTH(TAG_WIDTH),
        .SOURCE_WIDTH(SOURCE_WIDTH), .RSP_DEPTH(RSP_DEPTH), .WRITE_RSP(WRITE_RSP),
        .IRQ_PULSE(IRQ_PULSE)
    ) dut (
        .clock(clock), .reset(reset), .bus(bus), .msip(msip),
        .irq_out(irq_out), .busy(busy), .error(error)
    );

    always #5 clock = ~clock;

    // Reference model state
    a_exp_t               exp_a[$];
    rsp_t                 exp_rsp[$];
    infl_t                inflight[$];
    bit                   m_free[NUM_IDS];
    logic [TAG_WIDTH-1:0] m_tag[NUM_IDS];
    bit                   m_err;

    int n_checks = 0;
    int n_fails  = 0;

    bit     rand_en = 1'b0;
    logic   want_a_ready = 1'b1, want_rsp_ready = 1'b1;
    logic   rnd_a_ready  = 1'b1, rnd_rsp_ready  = 1'b1;
    d_drv_t d_dir, d_rnd;

    assign bus.tl_a_ready   = rand_en ? rnd_a_ready   : want_a_ready;
    assign bus.vx_rsp_ready = rand_en ? rnd_rsp_ready : want_rsp_ready;
    assign bus.tl_d_valid   = rand_en ? d_rnd.valid   : d_dir.valid;
    assign bus.tl_d_opcode  = rand_en ? d_rnd.opcode  : d_dir.opcode;
    assign bus.tl_d_source  = rand_en ? d_rnd.source  : d_dir.source;
    assign bus.tl_d_data    = rand_en ? d_rnd.data    : d_dir.data;
    assign bus.tl_d_denied  = rand_en ? d_rnd.denied  : d_dir.denied;
    assign bus.tl_d_corrupt = rand_en ? d_rnd.corrupt : d_dir.corrupt;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor/scoreboard: everything is sampled on the falling edge, i.e. the handshakes
    // that will complete at the next rising edge.
    int     mon_g;
    int     mon_src;
    a_exp_t mon_a;
    rsp_t   mon_r;
    always @(negedge clock) begin
        if (!reset) begin
            check("error_flag", error, m_err);
            if (bus.vx_req_valid && bus.vx_req_ready) begin
                mon_g = -1;
                for (int i = NUM_IDS - 1; i >= 0; i--) if (m_free[i]) mon_g = i;
                check("grant_available", (mon_g >= 0), 1'b1);
                if (mon_g >= 0) begin
                    mon_a.opcode = !bus.vx_req_rw ? 3'd4 :
                                   (bus.vx_req_byteen == {BYTES{1'b1}}) ? 3'd0 : 3'd1;
                    mon_a.mask   = bus.vx_req_rw ? bus.vx_req_byteen : {BYTES{1'b1}};
                    mon_a.addr   = TL_ADDR_WIDTH'(bus.vx_req_addr) * BYTES;
                    mon_a.data   = bus.vx_req_data;
                    mon_a.source = mon_g;
                    exp_a.push_back(mon_a);
                    m_free[mon_g] = 1'b0;
                    m_tag[mon_g]  = bus.vx_req_tag;
                end
            end
            if (bus.tl_a_valid && bus.tl_a_ready) begin
                if (exp_a.size() == 0) begin
                    check("a_unexpected", 1'b1, 1'b0);
                end else begin
                    mon_a = exp_a.pop_front();
                    check("a_opcode", bus.tl_a_opcode, mon_a.opcode);
                    check("a_address", bus.tl_a_address, mon_a.addr);
                    check("a_mask", bus.tl_a_mask, mon_a.mask);
                    check("a_source", bus.tl_a_source, mon_a.source);
                    check("a_size_param_corrupt",
                          {bus.tl_a_size, bus.tl_a_param, bus.tl_a_corrupt}, {4'd4, 3'd0, 1'b0});
                    if (mon_a.opcode != 3'd4) check("a_data", bus.tl_a_data, mon_a.data);
                    inflight.push_back('{source: mon_a.source, read: (mon_a.opcode == 3'd4)});
                end
            end
            if (bus.vx_rsp_valid && bus.vx_rsp_ready) begin
                if (exp_rsp.size() == 0) begin
                    check("rsp_unexpected", 1'b1, 1'b0);
                end else begin
                    mon_r = exp_rsp.pop_front();
                    check("rsp_tag", bus.vx_rsp_tag, mon_r.tag);
                    check("rsp_data", bus.vx_rsp_data, mon_r.data);
                end
            end
            if (bus.tl_d_valid && bus.tl_d_ready) begin
                mon_src = int'(bus.tl_d_source);
                if (bus.tl_d_denied || bus.tl_d_corrupt || m_free[mon_src] ||
                    bus.tl_d_opcode > 3'd1) m_err = 1'b1;
                if (bus.tl_d_opcode != 3'd0) begin
                    exp_rsp.push_back('{data: bus.tl_d_data, tag: m_tag[mon_src]});
                end else if (WRITE_RSP) begin
                    exp_rsp.push_back('{data: '0, tag: m_tag[mon_src]});
                end
                m_free[mon_src] = 1'b1;
            end
        end
    end

    // Random ready generation for the random phase.
    initial begin
        forever begin
            @(posedge clock); #1;
            rnd_a_ready   = ($urandom_range(0, 3) != 0);
            rnd_rsp_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Random fabric: answers any in-flight request, out of order.
    int    rsp_idx;
    infl_t rsp_it;
    bit    rsp_done;
    initial begin
        d_rnd = '{valid: 1'b0, opcode: 3'd1, source: '0, data: '0, denied: 1'b0, corrupt: 1'b0};
        forever begin
            @(posedge clock); #1;
            if (rand_en && inflight.size() > 0 && $urandom_range(0, 2) == 0) begin
                rsp_idx = $urandom_range(0, inflight.size() - 1);
                rsp_it  = inflight[rsp_idx];
                d_rnd.valid  = 1'b1;
                d_rnd.opcode = rsp_it.read ? 3'd1 : 3'd0;
                d_rnd.source = SOURCE_WIDTH'(rsp_it.source);
                d_rnd.data   = {$urandom, $urandom, $urandom, $urandom};
                rsp_done = 1'b0;
                for (int k = 0; k < 400 && !rsp_done; k++) begin
                    @(negedge clock);
                    if (bus.tl_d_ready) rsp_done = 1'b1;
                    @(posedge clock); #1;
                end
                d_rnd.valid = 1'b0;
                check("rand_d_handshake", rsp_done, 1'b1);
                inflight.delete(rsp_idx);
            end
        end
    end

    task automatic vx_send(input logic rw, input logic [BYTES-1:0] be,
                           input logic [ADDR_WIDTH-1:0] addr, input logic [DATA_WIDTH-1:0] data,
                           input logic [TAG_WIDTH-1:0] tag);
        bit done;
        done = 1'b0;
        bus.vx_req_valid  = 1'b1;
        bus.vx_req_rw     = rw;
        bus.vx_req_byteen = be;
        bus.vx_req_addr   = addr;
        bus.vx_req_data   = data;
        bus.vx_req_tag    = tag;
        for (int k = 0; k < 300 && !done; k++) begin
            @(negedge clock);
            if (bus.vx_req_ready) done = 1'b1;
            @(posedge clock); #1;
        end
        bus.vx_req_valid = 1'b0;
        check("vx_req_handshake", done, 1'b1);
    endtask

    task automatic d_send(input logic [2:0] op, input int src, input logic [DATA_WIDTH-1:0] data,
                          input bit denied, input bit corrupt);
        bit done;
        done = 1'b0;
        d_dir.valid   = 1'b1;
        d_dir.opcode  = op;
        d_dir.source  = SOURCE_WIDTH'(src);
        d_dir.data    = data;
        d_dir.denied  = denied;
        d_dir.corrupt = corrupt;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clock);
            if (bus.tl_d_ready) done = 1'b1;
            @(posedge clock); #1;
        end
        d_dir.valid   = 1'b0;
        d_dir.denied  = 1'b0;
        d_dir.corrupt = 1'b0;
        check("d_handshake", done, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clock); #1;
        end
    endtask

    bit drained;
    int hi_cnt;
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        d_dir = '{valid: 1'b0, opcode: 3'd1, source: '0, data: '0, denied: 1'b0, corrupt: 1'b0};
        bus.vx_req_valid = 1'b0; bus.vx_req_rw = 1'b0; bus.vx_req_byteen = '0;
        bus.vx_req_addr = '0; bus.vx_req_data = '0; bus.vx_req_tag = '0;
        for (int i = 0; i < NUM_IDS; i++) begin
            m_free[i] = 1'b1;
            m_tag[i]  = '0;
        end
        m_err = 1'b0;

        // Reset: every output low while reset is held.
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_outputs", {bus.vx_req_ready, bus.vx_rsp_valid, bus.tl_a_valid,
                                bus.tl_d_ready, irq_out, busy, error}, 7'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check("post_reset_ready_busy", {bus.vx_req_ready, busy}, 2'b10);
        @(posedge clock); #1;

        // Single read with fixed latencies.
        vx_send(1'b0, '1, 28'h0000123, '0, 15'h55);
        @(negedge clock);
        check("read_a_valid", bus.tl_a_valid, 1'b1);
        check("read_a_fields", {bus.tl_a_opcode, bus.tl_a_address, bus.tl_a_mask, bus.tl_a_size},
              {3'd4, 32'h00001230, 16'hFFFF, 4'd4});
        @(posedge clock); #1;
        d_send(3'd1, 0, 128'hDEADBEEF, 1'b0, 1'b0);
        @(negedge clock);
        check("read_rsp_next_cycle", {bus.vx_rsp_valid, bus.vx_rsp_tag, bus.vx_rsp_data},
              {1'b1, 15'h55, 128'hDEADBEEF});
        @(posedge clock); #1;

        // Partial and full writes; acks are absorbed.
        vx_send(1'b1, 16'h000F, 28'h0000040, 128'h0123456789ABCDEF, 15'h21);
        idle(2);
        d_send(3'd0, 0, '0, 1'b0, 1'b0);
        hi_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            if (bus.vx_rsp_valid) hi_cnt++;
            @(posedge clock); #1;
        end
        check("write_ack_absorbed", hi_cnt, 0);
        vx_send(1'b1, '1, 28'h0000041, 128'hCAFE, 15'h22);
        idle(2);
        d_send(3'd0, 0, '0, 1'b0, 1'b0);
        idle(2);

        // Out-of-order returns and ID exhaustion.
        for (int t = 1; t <= 4; t++) begin
            vx_send(1'b0, '1, ADDR_WIDTH'(t * 16), '0, TAG_WIDTH'(t));
        end
        bus.vx_req_valid = 1'b1; bus.vx_req_rw = 1'b0; bus.vx_req_byteen = '1;
        bus.vx_req_addr = 28'h500; bus.vx_req_tag = 15'd5;
        @(negedge clock);
        check("all_ids_busy_stall", bus.vx_req_ready, 1'b0);
        @(posedge clock); #1;
        d_send(3'd1, 3, 128'h4444, 1'b0, 1'b0);
        @(negedge clock);
        check("freed_id_grantable_next", bus.vx_req_ready, 1'b1);
        @(posedge clock); #1;
        bus.vx_req_valid = 1'b0;
        d_send(3'd1, 1, 128'h2222, 1'b0, 1'b0);
        d_send(3'd1, 0, 128'h1111, 1'b0, 1'b0);
        d_send(3'd1, 2, 128'h3333, 1'b0, 1'b0);
        d_send(3'd1, 3, 128'h5555, 1'b0, 1'b0);
        idle(4);

        // Backpressure: full FIFO stalls D; a single pop reopens it.
        want_rsp_ready = 1'b0;
        for (int t = 0; t < 4; t++) begin
            vx_send(1'b0, '1, ADDR_WIDTH'(t), '0, TAG_WIDTH'(16 + t));
        end
        for (int t = 0; t < 4; t++) begin
            d_send(3'd1, t, 128'(100 + t), 1'b0, 1'b0);
        end
        vx_send(1'b0, '1, 28'h99, '0, 15'd20);
        idle(1);
        d_dir.valid = 1'b1; d_dir.opcode = 3'd1; d_dir.source = '0; d_dir.data = 128'd104;
        @(negedge clock);
        check("full_fifo_d_stall", {bus.tl_d_ready, bus.vx_rsp_valid}, 2'b01);
        @(posedge clock); #1;
        want_rsp_ready = 1'b1;
        @(posedge clock); #1;
        want_rsp_ready = 1'b0;
        @(negedge clock);
        check("pop_reopens_d", bus.tl_d_ready, 1'b1);
        @(posedge clock); #1;
        d_dir.valid = 1'b0;
        want_rsp_ready = 1'b1;
        idle(8);
        check("directed_drained", {busy, 32'(exp_rsp.size())}, 33'd0);

        // Randomized out-of-order traffic.
        inflight.delete();
        rand_en = 1'b1;
        for (int n = 0; n < 300; n++) begin
            vx_send(1'($urandom_range(0, 1)),
                    ($urandom_range(0, 2) == 0) ? {BYTES{1'b1}} : BYTES'($urandom),
                    ADDR_WIDTH'($urandom), {$urandom, $urandom, $urandom, $urandom},
                    TAG_WIDTH'($urandom));
            idle($urandom_range(0, 2));
        end
        drained = 1'b0;
        for (int k = 0; k < 3000 && !drained; k++) begin
            @(negedge clock);
            if (inflight.size() == 0 && exp_a.size() == 0 && exp_rsp.size() == 0 &&
                !d_rnd.valid) drained = 1'b1;
        end
        check("random_drained", drained, 1'b1);
        @(posedge clock); #1;
        rand_en = 1'b0;
        idle(3);
        @(negedge clock);
        check("random_idle_busy", busy, 1'b0);
        @(posedge clock); #1;

        // Errors: denied response, then a response on a free source.
        vx_send(1'b0, '1, 28'h777, '0, 15'h77);
        idle(2);
        d_send(3'd1, 0, 128'hBAD, 1'b1, 1'b0);
        @(negedge clock);
        check("error_on_denied", error, 1'b1);
        @(posedge clock); #1;
        d_send(3'd1, 2, 128'hF2EE, 1'b0, 1'b0);
        idle(4);
        @(negedge clock);
        check("error_sticky_busy_low", {error, busy}, 2'b10);
        @(posedge clock); #1;

        // IRQ: single edge, retrigger mid-pulse, then held high.
        msip = 1'b1;
        hi_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            if (k == 0) check("irq_not_same_cycle", irq_out, 1'b0);
            else if (irq_out) hi_cnt++;
            @(posedge clock); #1;
        end
        check("irq_pulse_len", hi_cnt, IRQ_PULSE);
        msip = 1'b0;
        idle(2);
        hi_cnt = 0;
        for (int k = 0; k < 16; k++) begin
            msip = (k == 1 || k == 2) ? 1'b0 : 1'b1;
            @(negedge clock);
            if (irq_out) hi_cnt++;
            @(posedge clock); #1;
        end
        check("irq_retrigger_len", hi_cnt, 3 + IRQ_PULSE);
        hi_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            if (irq_out) hi_cnt++;
            @(posedge clock); #1;
        end
        check("irq_held_no_retrigger", hi_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
